// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: synchronises rising-edge sources into a
// W1C status register, masks them into a registered CPU request, OCP-style slave.
module intr_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [NSRC-1:0] i_irq,
    output logic            o_intr,
    input  logic [31:0]     i_MAddr,
    input  logic [2:0]      i_MCmd,
    input  logic [31:0]     i_MData,
    input  logic [3:0]      i_MByteEn,
    output logic            o_SCmdAccept,
    output logic [31:0]     o_SData,
    output logic [1:0]      o_SResp
);

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_WRITE = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b11;

    logic [NSRC-1:0] s1_r, s2_r, s3_r;
    logic [NSRC-1:0] ists_r, imask_r;
    logic            intr_r;
    logic [31:0]     sdata_r;
    logic [1:0]      sresp_r;

    logic            wr_s, rd_s, ok_s;
    logic [1:0]      sel_s;
    logic [31:0]     be_mask_s, wdata_m_s, rdata_s;
    logic [NSRC-1:0] wbits_s, edge_s, ists_clr_s, ists_nxt_s, imask_nxt_s;
    logic            unused_s;

    // Index of the lowest pending-and-enabled source, with "any" flag in bit 31.
    function automatic logic [31:0] ivec_f(input logic [NSRC-1:0] act);
        logic [4:0] idx;
        idx = 5'd0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (act[k]) begin
                idx = 5'(k);
            end else begin
                idx = idx;
            end
        end
        ivec_f = {|act, 26'd0, idx};
    endfunction

    function automatic logic [31:0] ext_f(input logic [NSRC-1:0] v);
        ext_f = 32'(v);
    endfunction

    assign edge_s       = s2_r & ~s3_r;
    assign o_SCmdAccept = (i_MCmd != CMD_IDLE);
    assign o_intr       = intr_r;
    assign o_SData      = sdata_r;
    assign o_SResp      = sresp_r;
    assign unused_s     = ^{i_MAddr[31:4], i_MAddr[1:0], wdata_m_s};

    // Command decode, byte-lane masking and next-state of the software registers.
    always_comb begin
        wr_s        = (i_MCmd == CMD_WRITE);
        rd_s        = (i_MCmd == CMD_READ);
        ok_s        = wr_s | rd_s;
        sel_s       = i_MAddr[3:2];
        be_mask_s   = {{8{i_MByteEn[3]}}, {8{i_MByteEn[2]}},
                       {8{i_MByteEn[1]}}, {8{i_MByteEn[0]}}};
        wdata_m_s   = i_MData & be_mask_s;
        wbits_s     = wdata_m_s[NSRC-1:0];
        if (wr_s && (sel_s == 2'd0)) begin
            ists_clr_s = wbits_s;
        end else begin
            ists_clr_s = {NSRC{1'b0}};
        end
        // An edge arriving with a clear of the same bit keeps the bit set.
        ists_nxt_s  = edge_s | (ists_r & ~ists_clr_s);
        if (wr_s && (sel_s == 2'd1)) begin
            imask_nxt_s = (imask_r & ~be_mask_s[NSRC-1:0]) | wbits_s;
        end else begin
            imask_nxt_s = imask_r;
        end
    end

    // Read mux over pre-update register values.
    always_comb begin
        rdata_s = 32'd0;
        case (sel_s)
            2'd0:    rdata_s = ext_f(ists_r);
            2'd1:    rdata_s = ext_f(imask_r);
            2'd2:    rdata_s = ext_f(s2_r);
            2'd3:    rdata_s = ivec_f(ists_r & imask_r);
            default: rdata_s = 32'd0;
        endcase
    end

    // Three-flop synchroniser per interrupt line.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_r <= {NSRC{1'b0}};
            s2_r <= {NSRC{1'b0}};
            s3_r <= {NSRC{1'b0}};
        end else begin
            s1_r <= i_irq;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Status, mask and the CPU request line.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ists_r  <= {NSRC{1'b0}};
            imask_r <= {NSRC{1'b0}};
            intr_r  <= 1'b0;
        end else begin
            ists_r  <= ists_nxt_s;
            imask_r <= imask_nxt_s;
            intr_r  <= |(ists_r & imask_r);
        end
    end

    // One-cycle registered bus response.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sresp_r <= RESP_NULL;
            sdata_r <= 32'd0;
        end else begin
            if (i_MCmd == CMD_IDLE) begin
                sresp_r <= RESP_NULL;
            end else if (ok_s) begin
                sresp_r <= RESP_DVA;
            end else begin
                sresp_r <= RESP_ERR;
            end
            sdata_r <= rd_s ? rdata_s : 32'd0;
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed plus randomized bench for intr_ctrl, compared every cycle against a
// history-based behavioural model of the controller.
module tb_intr_ctrl;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [7:0]  i_irq = 8'd0;
    logic        o_intr;
    logic [31:0] i_MAddr = 32'd0;
    logic [2:0]  i_MCmd = 3'd0;
    logic [31:0] i_MData = 32'd0;
    logic [3:0]  i_MByteEn = 4'd0;
    logic        o_SCmdAccept;
    logic [31:0] o_SData;
    logic [1:0]  o_SResp;

    int vectors = 0;
    int miscompares = 0;

    // Model state: h1..h3 are the line values sampled 1..3 edges ago.
    logic [7:0]  m_ists, m_imask, m_h1, m_h2, m_h3;
    logic        m_intr;
    logic [1:0]  m_resp;
    logic [31:0] m_sdata;

    intr_ctrl #(.NSRC(8)) dut (
        .clk(clk), .nrst(nrst), .i_irq(i_irq), .o_intr(o_intr),
        .i_MAddr(i_MAddr), .i_MCmd(i_MCmd), .i_MData(i_MData),
        .i_MByteEn(i_MByteEn), .o_SCmdAccept(o_SCmdAccept),
        .o_SData(o_SData), .o_SResp(o_SResp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ists = 8'd0; m_imask = 8'd0;
        m_h1 = 8'd0; m_h2 = 8'd0; m_h3 = 8'd0;
        m_intr = 1'b0; m_resp = 2'b00; m_sdata = 32'd0;
    endtask

    function automatic logic [31:0] model_ivec(input logic [7:0] act);
        int k;
        k = 0;
        while (k < 8 && !act[k]) k++;
        if (k == 8) return 32'd0;
        return 32'h8000_0000 | 32'(k);
    endfunction

    // One clock edge of the controller, computed from the behavioural rules.
    task automatic model_edge();
        logic [7:0]  ev, bem, clr;
        logic [31:0] rd;
        ev  = m_h2 & ~m_h3;
        bem = i_MByteEn[0] ? 8'hFF : 8'h00;
        case (i_MAddr[3:2])
            2'd0:    rd = 32'(m_ists);
            2'd1:    rd = 32'(m_imask);
            2'd2:    rd = 32'(m_h2);
            default: rd = model_ivec(m_ists & m_imask);
        endcase
        m_intr  = |(m_ists & m_imask);
        m_resp  = (i_MCmd == 3'd0) ? 2'b00 : (i_MCmd <= 3'd2) ? 2'b01 : 2'b11;
        m_sdata = (i_MCmd == 3'd2) ? rd : 32'd0;
        clr = (i_MCmd == 3'd1 && i_MAddr[3:2] == 2'd0) ? (i_MData[7:0] & bem) : 8'd0;
        if (i_MCmd == 3'd1 && i_MAddr[3:2] == 2'd1)
            m_imask = (m_imask & ~bem) | (i_MData[7:0] & bem);
        m_ists = ev | (m_ists & ~clr);
        m_h3 = m_h2; m_h2 = m_h1; m_h1 = i_irq;
    endtask

    task automatic compare_outputs();
        check("o_intr", 32'(o_intr), 32'(m_intr));
        check("o_SResp", 32'(o_SResp), 32'(m_resp));
        check("o_SData", o_SData, m_sdata);
    endtask

    // Drive one cycle from the negedge, advance the model, compare at next negedge.
    task automatic step(input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [7:0] irq);
        i_MCmd = cmd; i_MAddr = addr; i_MData = wdata; i_MByteEn = be; i_irq = irq;
        #1;
        check("accept", 32'(o_SCmdAccept), 32'(cmd != 3'd0));
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle(input logic [7:0] irq);
        step(3'd0, 32'd0, 32'd0, 4'd0, irq);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #1;
        model_reset();
        check("rst_intr", 32'(o_intr), 32'd0);
        check("rst_resp", 32'(o_SResp), 32'd0);
        check("rst_data", o_SData, 32'd0);
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        logic [7:0] irq;
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset state reads.
        step(3'd2, 32'h0, 32'd0, 4'd0, 8'h00);
        check("rst_ists", o_SData, 32'h0);
        check("rst_ists_dva", 32'(o_SResp), 32'h1);
        step(3'd2, 32'h4, 32'd0, 4'd0, 8'h00);
        check("rst_imask", o_SData, 32'h0);
        step(3'd2, 32'hC, 32'd0, 4'd0, 8'h00);
        check("rst_ivec", o_SData, 32'h0);

        // Single source latency and W1C.
        step(3'd1, 32'h4, 32'h0000_0004, 4'hF, 8'h00);
        idle(8'h04); idle(8'h04); idle(8'h04);
        check("lat_e2", 32'(o_intr), 32'd0);
        idle(8'h04);
        check("lat_e3", 32'(o_intr), 32'd1);
        step(3'd2, 32'hC, 32'd0, 4'd0, 8'h04);
        check("ivec2", o_SData, 32'h8000_0002);
        step(3'd1, 32'h0, 32'h4, 4'hF, 8'h04);
        check("w1c_w", 32'(o_intr), 32'd1);
        idle(8'h04);
        check("w1c_w1", 32'(o_intr), 32'd0);

        // Two sources, priority.
        step(3'd1, 32'h4, 32'hFF, 4'hF, 8'h26);
        idle(8'h26); idle(8'h26); idle(8'h26);
        step(3'd2, 32'hC, 32'd0, 4'd0, 8'h26);
        check("ivec1", o_SData, 32'h8000_0001);
        step(3'd1, 32'h0, 32'h2, 4'hF, 8'h26);
        step(3'd2, 32'hC, 32'd0, 4'd0, 8'h26);
        check("ivec5", o_SData, 32'h8000_0005);
        step(3'd1, 32'h0, 32'h20, 4'hF, 8'h26);

        // Edge on line 3 in the same cycle as its clear.
        idle(8'h2E); idle(8'h2E); idle(8'h2E); idle(8'h26); idle(8'h26);
        idle(8'h2E); idle(8'h2E);
        step(3'd1, 32'h0, 32'h8, 4'hF, 8'h2E);
        idle(8'h2E);
        check("setwins_intr", 32'(o_intr), 32'd1);
        step(3'd2, 32'h0, 32'd0, 4'd0, 8'h2E);
        check("setwins_ists", o_SData, 32'h8);

        // Masked source, then unmask.
        i_irq = 8'h00;
        do_reset();
        idle(8'h01); idle(8'h01); idle(8'h01); idle(8'h01);
        step(3'd2, 32'h0, 32'd0, 4'd0, 8'h01);
        check("masked_ists", o_SData, 32'h1);
        check("masked_intr", 32'(o_intr), 32'd0);
        step(3'd1, 32'h4, 32'h1, 4'hF, 8'h01);
        check("unmask_w", 32'(o_intr), 32'd0);
        idle(8'h01);
        check("unmask_w1", 32'(o_intr), 32'd1);

        // Invalid command and partial byte write.
        step(3'd4, 32'h4, 32'hFFFF_FFFF, 4'hF, 8'h01);
        check("err_resp", 32'(o_SResp), 32'h3);
        step(3'd2, 32'h4, 32'd0, 4'd0, 8'h01);
        check("err_nochg", o_SData, 32'h1);
        step(3'd1, 32'h4, 32'hFFFF_FFFF, 4'b0001, 8'h01);
        step(3'd2, 32'h4, 32'd0, 4'd0, 8'h01);
        check("be_imask", o_SData, 32'hFF);

        // Randomized traffic with occasional mid-run resets.
        irq = 8'h01;
        for (int c = 0; c < 3000; c++) begin
            int r;
            logic [2:0] cmd;
            if (c == 1000 || c == 2000) begin
                i_MCmd = 3'd2;
                do_reset();
            end
            if ($urandom_range(0, 5) == 0) irq[$urandom_range(0, 7)] ^= 1'b1;
            r = $urandom_range(0, 9);
            if (r < 3) cmd = 3'd0;
            else if (r < 6) cmd = 3'd1;
            else if (r < 9) cmd = 3'd2;
            else cmd = 3'($urandom_range(3, 7));
            step(cmd, $urandom, $urandom, 4'($urandom_range(0, 15)), irq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Memory-mapped interrupt controller on the system bus, acting as the source side of the CPU's external interrupt input. It accepts up to 32 asynchronous rising-edge interrupt lines and latches them into a status register. It masks them and drives a single registered interrupt request to the core, which the core gates with its Status.IE flag. Software reads the highest-priority vector and clears sources with write-one-to-clear through an OCP-style slave port.

## Interface
- NSRC, 8, number of interrupt sources (1..32); bits at and above NSRC are read as 0 and ignore writes.
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- i_irq  in  NSRC  interrupt lines, asynchronous, rising-edge sensitive
- o_intr  out  1  interrupt request to CPU, registered, active-high
- i_MAddr  in  32  byte address; only [3:2] decoded (block select done externally)
- i_MCmd  in  3  000 IDLE, 001 WRITE, 010 READ, others invalid
- i_MData  in  32  write data
- i_MByteEn  in  4  byte enables for writes
- o_SCmdAccept  out  1  command accepted (combinational)
- o_SData  out  32  read data, valid with o_SResp
- o_SResp  out  2  00 NULL, 01 DVA, 11 ERR

## Operation
- Synchronizer: per line s1<=i_irq, s2<=s1, s3<=s2. The edge event for line k is s2[k]&!s3[k].
- Registers, selected by i_MAddr[3:2]:
  - 0 ISTS: latched pending status. RO plus W1C.
  - 1 IMASK: RW, 1 = enabled.
  - 2 IRAW: RO, equals s2.
  - 3 IVEC: RO. Bit31 = any(ISTS&IMASK). Bits[4:0] = lowest index k with ISTS[k]&IMASK[k], else 0. Other bits 0.
- Writes apply only to bytes with i_MByteEn set. Writes to IRAW and IVEC are ignored but still return DVA.
- ISTS update per bit: next = edge | (ists & !(wr_ists & be_byte & wdata)). A set on the same cycle as a clear wins, so no edge is lost.
- ISTS latches regardless of IMASK. Unmasking a latched bit raises o_intr.
- o_intr <= |(ISTS & IMASK), evaluated from current register values every cycle.
- Bus:
  - o_SCmdAccept = (i_MCmd != IDLE); a command always completes in one cycle.
  - Response registered one cycle after accept: DVA for READ/WRITE, ERR for invalid codes.
  - o_SData carries read data on READ DVA; it is 0 on all other cycles.
  - Read data is the register value before any same-cycle update.
  - Back-to-back commands are supported, one response per cycle.
- Reset values: ISTS=0, IMASK=0, s1/s2/s3=0, o_intr=0, o_SResp=NULL, o_SData=0.
- Reset mid-operation clears everything, including any response not yet returned; no response is issued for a command that reset cut off.
- A line already high when reset releases produces no edge until s3 settles; s1..s3 start at 0, so a line held high through reset produces exactly one edge 2 cycles after release.

## Timing
- i_irq rise sampled at edge E0: s1 at E0, s2 at E1, ISTS set at E2, o_intr high after E3. Latency is 4 edges from first sample.
- W1C at edge W clears ISTS at W. o_intr drops after W+1 if nothing else is pending.
- IMASK write at W affects o_intr after W+1.
- Read response appears the cycle after accept, with o_SResp held for exactly 1 cycle.
- A pulse on i_irq shorter than one clock period may be missed. Sources must hold the line at least 2 cycles.

## Test plan
- Reset with i_irq=0 -> o_intr=0, reads of ISTS, IMASK and IVEC return 0x0 with DVA.
- IMASK=0x0000_0004, raise i_irq[2] -> o_intr=1 4 edges later; IVEC reads 0x8000_0002; write ISTS=0x4 -> o_intr=0 two edges later.
- i_irq[5] and i_irq[1] rise together, IMASK=0xFF -> IVEC=0x8000_0001; clear bit1 -> IVEC=0x8000_0005.
- Edge on line 3 in the same cycle as a W1C of bit 3 -> ISTS[3] remains 1 and o_intr stays high.
- Masked source: IMASK=0, raise i_irq[0] -> ISTS=0x1 and o_intr=0; then write IMASK=0x1 -> o_intr=1 after 2 edges.
- i_MCmd=3'b100 -> o_SCmdAccept=1, ERR next cycle, no register change. A write to IMASK with i_MByteEn=4'b0001 and data 0xFFFF_FFFF -> IMASK=0x0000_00FF (NSRC=8).
